// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the min-sort datapath and its slice feeder.
//   M              : number of words per batch (slice width)
//   DATA_W         : word width (number of bit-planes per batch)
//   feeder_state_t : slice feeder FSM states (LOAD, EMIT)
//   slice_t        : one M-bit bit-plane
// -----------------------------------------------------------------------------
package sort_pkg;

   localparam int M      = 4;
   localparam int DATA_W = 16;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } feeder_state_t;

   typedef logic [M-1:0] slice_t;

endpackage

// File: rtl/sort_slice_feeder_slice_select.sv
// -----------------------------------------------------------------------------
// slice_select
// Combinational bit-plane extractor: bit j of the plane is bit bit_idx of
// stored word j.
// Ports:
//   words   : M stored words of W bits each
//   bit_idx : plane index to extract
//   plane   : M-bit bit-plane
// -----------------------------------------------------------------------------
module slice_select #(
   parameter int M  = 4,
   parameter int W  = 16,
   parameter int BW = 4
) (
   input  logic [W-1:0]  words [M],
   input  logic [BW-1:0] bit_idx,
   output logic [M-1:0]  plane
);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which is what would otherwise infer a latch.
   always_comb begin
      plane = '0;
      for (int j = 0; j < M; j++) begin
         plane[j] = words[j][bit_idx];
      end
   end

endmodule

// File: rtl/sort_slice_feeder.sv
// -----------------------------------------------------------------------------
// sort_slice_feeder
// Bit-plane transposer feeding the min-sort slice chain. Buffers a batch of M
// W-bit words from a valid/ready stream, then emits W slices of M bits, MSB
// plane first. Loading and emitting never overlap (single buffer).
// Ports:
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   i_s_valid/o_s_ready      : upstream word handshake
//   i_s_data                 : upstream word (first accepted word = slice bit 0)
//   o_m_valid/i_m_ready      : downstream slice handshake
//   o_m_slice                : bit-plane, bit j = bit o_m_bit_idx of word j
//   o_m_bit_idx              : plane index of current slice
//   o_m_last                 : current slice is plane 0 (end of batch)
//   o_busy                   : a batch is partially loaded or being emitted
// Configuration macro:
//   SORT_FEEDER_MAX_MODE_EN  : emit inverted planes so the core finds the max
// -----------------------------------------------------------------------------
module sort_slice_feeder #(
   parameter  int M  = sort_pkg::M,
   parameter  int W  = sort_pkg::DATA_W,
   localparam int BW = (W > 1) ? $clog2(W) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_s_valid,
   output logic          o_s_ready,
   input  logic [W-1:0]  i_s_data,
   output logic          o_m_valid,
   input  logic          i_m_ready,
   output logic [M-1:0]  o_m_slice,
   output logic [BW-1:0] o_m_bit_idx,
   output logic          o_m_last,
   output logic          o_busy
);

   import sort_pkg::*;

   localparam int            CW     = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST_W = CW'(M - 1);
   localparam logic [BW-1:0] TOP_B  = BW'(W - 1);

   feeder_state_t state, state_next;
   logic [CW-1:0] wcnt;
   logic [BW-1:0] bit_idx;
   logic [W-1:0]  words [M];
   logic [M-1:0]  plane;
   logic [M-1:0]  shown;
   logic          s_fire;
   logic          m_fire;

   assign s_fire = i_s_valid && o_s_ready;
   assign m_fire = o_m_valid && i_m_ready;

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      o_s_ready  = 1'b0;
      o_m_valid  = 1'b0;
      case (state)
         LOAD: begin
            o_s_ready = 1'b1;
            if (i_s_valid && wcnt == LAST_W) state_next = EMIT;
         end
         EMIT: begin
            o_m_valid = 1'b1;
            if (i_m_ready && bit_idx == '0) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= LOAD;
         wcnt    <= '0;
         bit_idx <= '0;
      end else begin
         state <= state_next;
         if (s_fire) begin
            if (wcnt == LAST_W) begin
               wcnt    <= '0;
               bit_idx <= TOP_B;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end
         if (m_fire && bit_idx != '0) bit_idx <= bit_idx - 1'b1;
      end
   end

   // NOTE: the word buffer has no reset; every entry is written before it is
   // read, and leaving it out keeps the storage a plain register array.
   always_ff @(posedge i_clk) begin
      if (s_fire) words[wcnt] <= i_s_data;
   end

   slice_select #(
      .M  (M),
      .W  (W),
      .BW (BW)
   ) u_slice_select (
      .words   (words),
      .bit_idx (bit_idx),
      .plane   (plane)
   );

`ifdef SORT_FEEDER_MAX_MODE_EN
   // Inverted planes turn the downstream minimum search into a maximum search.
   assign shown = ~plane;
`else
   assign shown = plane;
`endif

   // Slice-side outputs are forced to zero whenever no slice is offered.
   assign o_m_slice   = o_m_valid ? shown : '0;
   assign o_m_bit_idx = o_m_valid ? bit_idx : '0;
   assign o_m_last    = o_m_valid && (bit_idx == '0);
   assign o_busy      = (wcnt != '0) || (state == EMIT);

endmodule

// File: tb/tb_sort_slice_feeder.sv
// -----------------------------------------------------------------------------
// tb_sort_slice_feeder
// Self-checking bench for sort_slice_feeder with M=4, W=4. A reference model
// derives every expected slice directly from the stored batch; outputs are
// sampled on the falling clock edge and inputs are driven there too.
// Honors SORT_FEEDER_MAX_MODE_EN (expected planes are inverted).
// -----------------------------------------------------------------------------
module tb_sort_slice_feeder;

   localparam int M  = 4;
   localparam int W  = 4;
   localparam int BW = 2;

   logic          clk;
   logic          i_rst;
   logic          i_s_valid;
   logic          o_s_ready;
   logic [W-1:0]  i_s_data;
   logic          o_m_valid;
   logic          i_m_ready;
   logic [M-1:0]  o_m_slice;
   logic [BW-1:0] o_m_bit_idx;
   logic          o_m_last;
   logic          o_busy;

   int total;
   int passed;

   sort_slice_feeder #(.M(M), .W(W)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_s_valid   (i_s_valid),
      .o_s_ready   (o_s_ready),
      .i_s_data    (i_s_data),
      .o_m_valid   (o_m_valid),
      .i_m_ready   (i_m_ready),
      .o_m_slice   (o_m_slice),
      .o_m_bit_idx (o_m_bit_idx),
      .o_m_last    (o_m_last),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plane b of a batch collects bit b of every word, word j -> bit j.
   function automatic logic [M-1:0] plane_of(input logic [W-1:0] w [M], input int b);
      logic [M-1:0] r;
      for (int j = 0; j < M; j++) r[j] = w[j][b];
`ifdef SORT_FEEDER_MAX_MODE_EN
      r = ~r;
`endif
      return r;
   endfunction

   // Output vector layout: {s_ready, m_valid, slice, bit_idx, last, busy}
   function automatic logic [9:0] outs();
      return {o_s_ready, o_m_valid, o_m_slice, o_m_bit_idx, o_m_last, o_busy};
   endfunction

   // Drives one batch. gap_mode: 0 continuous, 1 alternating, 2 random.
   // stall_mode: 0 none, 1 random, 2 three-cycle stall on plane 2.
   // abort_plane >= 0 asserts reset while that plane is offered.
   task automatic feed_batch(input logic [W-1:0] w [M], input int gap_mode,
                             input int stall_mode, input int abort_plane,
                             output logic [M-1:0] got [W], output int cycles);
      int idx = 0;
      int pl = W - 1;
      int stalls = 0;
      bit done = 0;
      bit v;
      bit r;
      logic [9:0] exp_v;
      cycles = 0;
      for (int k = 0; k < W; k++) got[k] = '0;
      while (!done && cycles < 400) begin
         @(negedge clk);
         cycles++;
         if (idx < M) begin
            exp_v = {1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, (idx != 0)};
            total++;
            if (outs() !== exp_v)
               $display("FAIL load idx=%0d: got %b want %b", idx, outs(), exp_v);
            else passed++;
            case (gap_mode)
               0:       v = 1'b1;
               1:       v = (cycles % 2 == 0);
               default: v = ($urandom_range(0, 2) != 0);
            endcase
            i_s_valid = v;
            i_s_data  = v ? w[idx] : W'($urandom);
            i_m_ready = 1'($urandom_range(0, 1));
            if (v) idx++;
         end else begin
            exp_v = {1'b0, 1'b1, plane_of(w, pl), 2'(pl), (pl == 0), 1'b1};
            total++;
            if (outs() !== exp_v)
               $display("FAIL emit plane=%0d: got %b want %b", pl, outs(), exp_v);
            else passed++;
            got[pl]   = o_m_slice;
            i_s_valid = 1'($urandom_range(0, 1));
            i_s_data  = W'($urandom);
            if (pl == abort_plane) begin
               i_rst = 1'b1;
               #1;
               total++;
               if (outs() !== 10'b10_0000_00_0_0)
                  $display("FAIL async_reset: got %b want %b", outs(), 10'b10_0000_00_0_0);
               else passed++;
               #1 i_rst = 1'b0;
               done = 1;
            end else begin
               if (stall_mode == 2) r = !(pl == 2 && stalls < 3);
               else if (stall_mode == 1) r = 1'($urandom_range(0, 1));
               else r = 1'b1;
               if (!r) stalls++;
               i_m_ready = r;
               if (r) begin
                  if (pl == 0) done = 1;
                  else pl--;
               end
            end
         end
      end
      if (!done) begin
         total++;
         $display("FAIL timeout: batch incomplete after %0d cycles, want completion", cycles);
      end
   endtask

   task automatic check_spec_planes(input string name, input logic [M-1:0] got [W],
                                    input logic [M-1:0] want [W]);
      for (int k = 0; k < W; k++) begin
`ifdef SORT_FEEDER_MAX_MODE_EN
         want[k] = ~want[k];
`endif
         total++;
         if (got[k] !== want[k])
            $display("FAIL %s plane %0d: got %b want %b", name, k, got[k], want[k]);
         else passed++;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge clk);
      i_s_valid = 1'b1;
      i_m_ready = 1'b1;
      i_s_data  = 4'hF;
      @(negedge clk);
      total++;
      if (outs() !== 10'b10_0000_00_0_0)
         $display("FAIL reset_state: got %b want %b", outs(), 10'b10_0000_00_0_0);
      else passed++;
      i_s_valid = 1'b0;
      i_rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] w [M];
      logic [M-1:0] got [W];
      logic [M-1:0] want [W];
      int cyc;
      w = '{4'd5, 4'd3, 4'd7, 4'd3};
      want = '{4'b1111, 4'b1110, 4'b0101, 4'b0000};
      feed_batch(w, 0, 0, -1, got, cyc);
      check_spec_planes("basic", got, want);
      @(negedge clk);
      i_s_valid = 1'b0;
      total++;
      if (outs() !== 10'b10_0000_00_0_0)
         $display("FAIL ready_return: got %b want %b", outs(), 10'b10_0000_00_0_0);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] w [M];
      logic [M-1:0] got [W];
      logic [M-1:0] want [W];
      int cyc;
      w = '{4'd5, 4'd3, 4'd7, 4'd3};
      want = '{4'b1111, 4'b1110, 4'b0101, 4'b0000};
      feed_batch(w, 0, 2, -1, got, cyc);
      check_spec_planes("backpressure", got, want);
      total++;
      if (cyc !== 11) $display("FAIL backpressure_cycles: got %0d want %0d", cyc, 11);
      else passed++;
   endtask

   task automatic test_gapped();
      logic [W-1:0] w [M];
      logic [M-1:0] got [W];
      int cyc;
      for (int j = 0; j < M; j++) w[j] = W'($urandom);
      feed_batch(w, 1, 0, -1, got, cyc);
   endtask

   task automatic test_reset_mid_emit();
      logic [W-1:0] w [M];
      logic [M-1:0] got [W];
      logic [M-1:0] want [W];
      int cyc;
      for (int j = 0; j < M; j++) w[j] = W'($urandom);
      feed_batch(w, 0, 0, 1, got, cyc);
      w = '{4'd15, 4'd0, 4'd15, 4'd0};
      want = '{4'b0101, 4'b0101, 4'b0101, 4'b0101};
      feed_batch(w, 0, 0, -1, got, cyc);
      check_spec_planes("after_reset", got, want);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w [M];
      logic [M-1:0] got [W];
      int c1, c2;
      for (int j = 0; j < M; j++) w[j] = W'($urandom);
      feed_batch(w, 0, 0, -1, got, c1);
      for (int j = 0; j < M; j++) w[j] = ~w[j];
      feed_batch(w, 0, 0, -1, got, c2);
      total++;
      if (c1 + c2 !== 16) $display("FAIL back_to_back_cycles: got %0d want %0d", c1 + c2, 16);
      else passed++;
   endtask

   task automatic test_random();
      logic [W-1:0] w [M];
      logic [M-1:0] got [W];
      int cyc;
      int ab;
      for (int n = 0; n < 20; n++) begin
         for (int j = 0; j < M; j++) w[j] = W'($urandom);
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1;
         feed_batch(w, 2, 1, ab, got, cyc);
      end
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      i_rst     = 1'b1;
      i_s_valid = 1'b0;
      i_s_data  = '0;
      i_m_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_gapped();
      test_reset_mid_emit();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
